// File: rtl/spi_slave_param.sv
// SPI slave oversampled in the clk domain: all four CPOL/CPHA modes, parametric
// word width and bit order, multi-word bursts, valid/ready word handshakes.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int   CW          = $clog2(DATA_W + 1);
  localparam logic SCK_IDLE    = (CPOL != 0);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);
  localparam logic MSBF        = (MSB_FIRST != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync, vld_pipe;
  logic sck_d, cs_d, armed;
  logic sck_s, mosi_s, cs_s;
  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
  logic start, word_done, tx_load;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] hold, tx_sh, rx_sh, rx_next, tx_word;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSBF ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] w);
    return MSBF ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // vld_pipe marks when cs_s holds a real pin sample rather than reset fill,
  // so a cs held low through reset is not mistaken for a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      vld_pipe  <= '0;
      sck_d     <= SCK_IDLE;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (vld_pipe[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign busy        = ~cs_s;
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign cs_fall     = armed & cs_d & ~cs_s;
  assign cs_rise     = cs_s & ~cs_d;

  assign rx_next = MSBF ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
  assign tx_word = tx_ready ? '0 : hold;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    word_done = 1'b0;
    tx_load   = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_nxt = ACTIVE;
        start     = 1'b1;
        tx_load   = 1'b1;
      end
      ACTIVE: begin
        if (cs_rise) state_nxt = IDLE;
        else if (sample_edge && cnt == CW'(DATA_W - 1)) begin
          word_done = 1'b1;
          tx_load   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b1;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      hold        <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      cnt         <= '0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      // A load empties the holding register; a write is only taken while empty.
      if (tx_load && !tx_ready) tx_ready <= 1'b1;
      else if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end
      if (tx_load && tx_ready) tx_underrun <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt  <= '0;
          miso <= 1'b0;
          if (start) begin
            if (CPHA == 0) begin
              miso  <= first_bit(tx_word);
              tx_sh <= shifted(tx_word);
            end else begin
              tx_sh <= tx_word;
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            cnt  <= '0;
            miso <= 1'b0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (word_done) begin
              cnt   <= '0;
              tx_sh <= tx_word;
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (shift_edge) begin
            miso  <= first_bit(tx_sh);
            tx_sh <= shifted(tx_sh);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench: behavioural SPI master drives five slave instances (8-bit mode 0 MSB
// first, and 16-bit LSB first in each of the four modes) and checks both directions.
module tb_spi_slave_param;

  localparam int N = 5;
  localparam int H = 6; // master half-period in clk cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;
  logic [N-1:0] sck_v, cs_v, txv_v, rxr_v;
  wire  [N-1:0] miso_v, txr_v, rxv_v, ovr_v, und_v, bsy_v;
  logic [15:0]  txd [N];
  wire  [15:0]  rxd [N];

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int ovr_cnt = 0;
  int und_cnt = 0;
  int und_at_start = 0;
  logic [15:0] rx_got[$];
  logic [15:0] rd_q[$];
  logic [15:0] m_q[$];
  logic [15:0] t_q[$];

  always #5 clk = ~clk;

  function automatic int dw_of(input int i);   return (i == 0) ? 8 : 16; endfunction
  function automatic int cpol_of(input int i); return (i == 0) ? 0 : ((i - 1) >> 1); endfunction
  function automatic int cpha_of(input int i); return (i == 0) ? 0 : ((i - 1) & 1); endfunction
  function automatic bit msb_of(input int i);  return (i == 0); endfunction

  genvar g;
  for (g = 0; g < N; g++) begin : gi
    localparam int DW = (g == 0) ? 8 : 16;
    localparam int PL = (g == 0) ? 0 : ((g - 1) >> 1);
    localparam int PH = (g == 0) ? 0 : ((g - 1) & 1);
    localparam int MF = (g == 0) ? 1 : 0;
    wire [DW-1:0] rw;
    spi_slave_param #(.DATA_W(DW), .CPOL(PL), .CPHA(PH), .MSB_FIRST(MF), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .sck(sck_v[g]), .mosi(mosi), .cs(cs_v[g]), .miso(miso_v[g]),
      .tx_data(txd[g][DW-1:0]), .tx_valid(txv_v[g]), .tx_ready(txr_v[g]),
      .rx_data(rw), .rx_valid(rxv_v[g]), .rx_ready(rxr_v[g]),
      .rx_overrun(ovr_v[g]), .tx_underrun(und_v[g]), .busy(bsy_v[g]));
    assign rxd[g] = 16'(rw);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rxv_v[sel] && rxr_v[sel]) rx_got.push_back(rxd[sel]);
      if (ovr_v[sel]) ovr_cnt++;
      if (und_v[sel]) und_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_tx(input int idx, input logic [15:0] w);
    int n = 0;
    while (!txr_v[idx] && n < 4000) begin @(negedge clk); n++; end
    total++;
    if (!txr_v[idx]) begin
      bad++;
      $display("FAIL push_tx timeout inst=%0d got tx_ready=0 want 1", idx);
    end
    txd[idx]  = w;
    txv_v[idx] = 1'b1;
    @(negedge clk);
    txv_v[idx] = 1'b0;
  endtask

  // Plain SPI master: shifts m_q out on mosi, collects miso words into rd_q.
  task automatic master(input int idx, input int nbits, input bit raise);
    int dw = dw_of(idx);
    logic pol = cpol_of(idx) != 0;
    logic [15:0] rw = '0;
    cs_v[idx] = 1'b0;
    repeat (H) @(negedge clk);
    und_at_start = und_cnt;
    for (int b = 0; b < nbits; b++) begin
      int bi  = b % dw;
      int pos = msb_of(idx) ? dw - 1 - bi : bi;
      logic [15:0] w = m_q[b / dw];
      if (cpha_of(idx) == 0) begin
        mosi = w[pos];
        repeat (H) @(negedge clk);
        rw[pos] = miso_v[idx];
        sck_v[idx] = ~pol;
        repeat (H) @(negedge clk);
        sck_v[idx] = pol;
      end else begin
        sck_v[idx] = ~pol;
        mosi = w[pos];
        repeat (H) @(negedge clk);
        rw[pos] = miso_v[idx];
        sck_v[idx] = pol;
        repeat (H) @(negedge clk);
      end
      if (bi == dw - 1) begin rd_q.push_back(rw); rw = '0; end
    end
    repeat (H) @(negedge clk);
    if (raise) begin
      cs_v[idx] = 1'b1;
      repeat (2 * H) @(negedge clk);
    end
  endtask

  task automatic frame(input int idx, input int nbits, input bit raise);
    sel = idx;
    rx_got.delete();
    rd_q.delete();
    ovr_cnt = 0;
    und_cnt = 0;
    if (t_q.size() > 0) push_tx(idx, t_q[0]);
    fork
      master(idx, nbits, raise);
      for (int k = 1; k < t_q.size(); k++) push_tx(idx, t_q[k]);
    join
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({miso_v[i], rxv_v[i], txr_v[i], ovr_v[i], und_v[i], bsy_v[i]} !== 6'b001000) begin
        bad++;
        $display("FAIL reset_flags inst=%0d got %b want 001000", i,
                 {miso_v[i], rxv_v[i], txr_v[i], ovr_v[i], und_v[i], bsy_v[i]});
      end
      total++;
      if (rxd[i] !== 16'h0) begin
        bad++;
        $display("FAIL reset_rx_data inst=%0d got %h want 0000", i, rxd[i]);
      end
    end
  endtask

  task automatic test_mode0;
    m_q = '{16'h003C};
    t_q = '{16'h00A5};
    frame(0, 8, 1);
    total++;
    if (rx_got.size() != 1 || rx_got[0] !== 16'h3C) begin
      bad++;
      $display("FAIL mode0_rx got n=%0d first=%h want 003c", rx_got.size(),
               rx_got.size() > 0 ? rx_got[0] : 16'hxxxx);
    end
    total++;
    if (rd_q[0] !== 16'hA5) begin bad++; $display("FAIL mode0_miso got %h want 00a5", rd_q[0]); end
    total++;
    if (und_at_start != 0) begin bad++; $display("FAIL mode0_underrun got %0d want 0", und_at_start); end
  endtask

  task automatic test_modes;
    for (int i = 1; i < N; i++) begin
      m_q = '{16'h1234, 16'($urandom)};
      t_q = '{16'hBEEF, 16'($urandom)};
      frame(i, 32, 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rx_got.size() <= k || rx_got[k] !== m_q[k]) begin
          bad++;
          $display("FAIL modes_rx inst=%0d word=%0d got %h want %h", i, k,
                   rx_got.size() > k ? rx_got[k] : 16'hxxxx, m_q[k]);
        end
        total++;
        if (rd_q[k] !== t_q[k]) begin
          bad++;
          $display("FAIL modes_miso inst=%0d word=%0d got %h want %h", i, k, rd_q[k], t_q[k]);
        end
      end
    end
  endtask

  task automatic test_burst;
    m_q = '{16'($urandom_range(255)), 16'($urandom_range(255)), 16'($urandom_range(255))};
    t_q = '{16'h11, 16'h22, 16'h33};
    frame(0, 24, 1);
    total++;
    if (rx_got.size() != 3) begin bad++; $display("FAIL burst_count got %0d want 3", rx_got.size()); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rx_got.size() <= k || rx_got[k] !== m_q[k]) begin
        bad++;
        $display("FAIL burst_rx word=%0d got %h want %h", k,
                 rx_got.size() > k ? rx_got[k] : 16'hxxxx, m_q[k]);
      end
      total++;
      if (rd_q[k] !== t_q[k]) begin bad++; $display("FAIL burst_miso word=%0d got %h want %h", k, rd_q[k], t_q[k]); end
    end
  endtask

  task automatic test_overrun_underrun;
    rxr_v[0] = 1'b0;
    m_q = '{16'($urandom_range(255)), 16'($urandom_range(255))};
    t_q = '{16'($urandom_range(255)), 16'($urandom_range(255))};
    frame(0, 16, 1);
    total++;
    if (rxv_v[0] !== 1'b1 || rxd[0] !== m_q[0]) begin
      bad++;
      $display("FAIL overrun_hold got valid=%b data=%h want 1 %h", rxv_v[0], rxd[0], m_q[0]);
    end
    total++;
    if (ovr_cnt != 1) begin bad++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt); end
    total++;
    if (rd_q[1] !== t_q[1]) begin bad++; $display("FAIL overrun_miso got %h want %h", rd_q[1], t_q[1]); end
    rxr_v[0] = 1'b1;
    @(negedge clk);
    total++;
    if (rxv_v[0] !== 1'b0) begin bad++; $display("FAIL rx_accept got valid=%b want 0", rxv_v[0]); end

    m_q = '{16'($urandom_range(255))};
    t_q.delete();
    frame(0, 8, 1);
    total++;
    if (rd_q[0] !== 16'h0) begin bad++; $display("FAIL underrun_miso got %h want 0000", rd_q[0]); end
    total++;
    if (und_at_start != 1) begin bad++; $display("FAIL underrun_at_cs got %0d want 1", und_at_start); end
    total++;
    if (rx_got.size() != 1 || rx_got[0] !== m_q[0]) begin
      bad++;
      $display("FAIL underrun_rx got n=%0d want 1 word %h", rx_got.size(), m_q[0]);
    end
  endtask

  task automatic test_partial;
    m_q = '{16'($urandom_range(255))};
    t_q = '{16'($urandom_range(255))};
    frame(0, 5, 1);
    total++;
    if (rx_got.size() != 0) begin bad++; $display("FAIL partial_rx got %0d words want 0", rx_got.size()); end
    m_q = '{16'h7E};
    t_q = '{16'($urandom_range(255))};
    frame(0, 8, 1);
    total++;
    if (rx_got.size() != 1 || rx_got[0] !== 16'h7E) begin
      bad++;
      $display("FAIL after_partial_rx got n=%0d first=%h want 007e", rx_got.size(),
               rx_got.size() > 0 ? rx_got[0] : 16'hxxxx);
    end
    total++;
    if (rd_q[0] !== t_q[0]) begin bad++; $display("FAIL after_partial_miso got %h want %h", rd_q[0], t_q[0]); end
  endtask

  task automatic test_reset_mid;
    m_q = '{16'($urandom_range(255))};
    t_q = '{16'($urandom_range(255))};
    frame(0, 4, 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({miso_v[0], rxv_v[0], txr_v[0], ovr_v[0], und_v[0], bsy_v[0]} !== 6'b001000 || rxd[0] !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid got flags=%b data=%h want 001000 0000",
               {miso_v[0], rxv_v[0], txr_v[0], ovr_v[0], und_v[0], bsy_v[0]}, rxd[0]);
    end
    rst = 1'b0;
    und_cnt = 0;
    repeat (10) @(negedge clk);
    total++;
    if (und_cnt != 0) begin bad++; $display("FAIL reset_cs_low_start got underruns=%0d want 0", und_cnt); end
    cs_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    m_q = '{16'($urandom_range(255))};
    t_q = '{16'($urandom_range(255))};
    frame(0, 8, 1);
    total++;
    if (rx_got.size() != 1 || rx_got[0] !== m_q[0]) begin
      bad++;
      $display("FAIL post_reset_rx got n=%0d want 1 word %h", rx_got.size(), m_q[0]);
    end
    total++;
    if (rd_q[0] !== t_q[0]) begin bad++; $display("FAIL post_reset_miso got %h want %h", rd_q[0], t_q[0]); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sck_v[i] = (cpol_of(i) != 0);
      txd[i]   = '0;
    end
    cs_v  = '1;
    txv_v = '0;
    rxr_v = '1;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    test_mode0;
    test_modes;
    test_burst;
    test_overrun_underrun;
    test_partial;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
